// File: rtl/writeback_module.sv
// Write-back stage of the RV32I pipeline: load extraction, write-value select,
// the 32x32 integer register file with bypassed read ports, and the WB forwarding bundle.
module writeback_module #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clk_en,
   input  logic            i_ma_mem_to_reg,
   input  logic [1:0]      i_ma_rw_sel,
   input  logic            i_ma_reg_wr,
   input  logic [4:0]      i_ma_reg_dest,
   input  logic [XLEN-1:0] i_ma_result,
   input  logic [XLEN-1:0] i_ma_read_data,
   input  logic [XLEN-1:0] i_ma_pc_plus_4,
   input  logic [2:0]      i_ma_funct3,
   input  logic [4:0]      i_rs1_addr,
   input  logic [4:0]      i_rs2_addr,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic            o_wb_reg_wr,
   output logic [4:0]      o_wb_reg_dest,
   output logic [XLEN-1:0] o_wb_data,
   output logic            o_wb_misaligned,
   output logic [31:0]     o_wb_count
);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [1:0]      offset;
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_value;
   logic            misaligned_load;
   logic            write_req;
   logic            commit;
   logic            bypass_en;

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wb_reg_wr_q,   wb_reg_wr_d;
   logic [4:0]      wb_reg_dest_q, wb_reg_dest_d;
   logic [XLEN-1:0] wb_data_q,     wb_data_d;
   logic            misaligned_q,  misaligned_d;
   logic [31:0]     count_q,       count_d;

   assign offset = i_ma_result[1:0];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      load_byte = i_ma_read_data[7:0];
      case (offset)
         2'd1:    load_byte = i_ma_read_data[15:8];
         2'd2:    load_byte = i_ma_read_data[23:16];
         2'd3:    load_byte = i_ma_read_data[31:24];
         default: load_byte = i_ma_read_data[7:0];
      endcase
      load_half = offset[1] ? i_ma_read_data[31:16] : i_ma_read_data[15:0];

      load_data = i_ma_read_data;
      case (i_ma_funct3)
         F3_LB:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
         F3_LBU:  load_data = {{(XLEN-8){1'b0}}, load_byte};
         F3_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
         F3_LHU:  load_data = {{(XLEN-16){1'b0}}, load_half};
         default: load_data = i_ma_read_data;
      endcase
   end

   always_comb begin
      if (i_ma_mem_to_reg)
         wb_value = load_data;
      else if (i_ma_rw_sel == 2'b10)
         wb_value = i_ma_pc_plus_4;
      else
         wb_value = i_ma_result;
   end

   // Writes to x0 are dropped before the alignment check, so they never raise the pulse.
   assign write_req = i_clk_en & i_ma_reg_wr & (i_ma_reg_dest != 5'd0);
   assign misaligned_load = write_req & i_ma_mem_to_reg &
                            ((((i_ma_funct3 == F3_LH) || (i_ma_funct3 == F3_LHU)) && offset[0]) ||
                             ((i_ma_funct3 == F3_LW) && (offset != 2'd0)));
   assign commit    = write_req & ~misaligned_load;
   assign bypass_en = commit & i_rst_n;

   always_comb begin
      o_rs1_data = '0;
      if (i_rs1_addr != 5'd0)
         o_rs1_data = (bypass_en && (i_rs1_addr == i_ma_reg_dest)) ? wb_value : regs_q[i_rs1_addr];
      o_rs2_data = '0;
      if (i_rs2_addr != 5'd0)
         o_rs2_data = (bypass_en && (i_rs2_addr == i_ma_reg_dest)) ? wb_value : regs_q[i_rs2_addr];
   end

   always_comb begin
      wb_reg_wr_d   = wb_reg_wr_q;
      wb_reg_dest_d = wb_reg_dest_q;
      wb_data_d     = wb_data_q;
      misaligned_d  = misaligned_q;
      count_d       = count_q;
      if (i_clk_en) begin
         wb_reg_wr_d  = commit;
         misaligned_d = misaligned_load;
         if (commit) begin
            wb_reg_dest_d = i_ma_reg_dest;
            wb_data_d     = wb_value;
            count_d       = count_q + 32'd1;
         end
      end
   end

   // NOTE: the register array is cleared by reset because software may read any register before writing it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
      end else if (commit) begin
         regs_q[i_ma_reg_dest] <= wb_value;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wb_reg_wr_q   <= 1'b0;
         wb_reg_dest_q <= 5'd0;
         wb_data_q     <= '0;
         misaligned_q  <= 1'b0;
         count_q       <= 32'd0;
      end else begin
         wb_reg_wr_q   <= wb_reg_wr_d;
         wb_reg_dest_q <= wb_reg_dest_d;
         wb_data_q     <= wb_data_d;
         misaligned_q  <= misaligned_d;
         count_q       <= count_d;
      end
   end

   assign o_wb_reg_wr     = wb_reg_wr_q;
   assign o_wb_reg_dest   = wb_reg_dest_q;
   assign o_wb_data       = wb_data_q;
   assign o_wb_misaligned = misaligned_q;
   assign o_wb_count      = count_q;

endmodule
